prio_enc_rr: RTL and testbench

- Parametrised, registered successor to the team's 4x2 encoder.
- Encodes an N-bit request vector to a binary index, with two arbitration modes:
  - fixed priority: highest index wins
  - round-robin: rotating start pointer
- Valid/ready handshakes on both sides; one-cycle registered latency.
- Used as the grant encoder in front of shared datapath resources.

---
 rtl/prio_enc_rr_if.sv | 24 ++
 rtl/prio_enc_rr.sv | 86 ++++++++
 tb/tb_prio_enc_rr.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/prio_enc_rr_if.sv
// prio_enc_rr_if: request/grant handshake bundle for prio_enc_rr
interface prio_enc_rr_if #(
   parameter int N = 8,
   parameter int W = $clog2(N)
);
   logic         mode;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] req;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic         out_none;
   logic         out_multi;
   modport master (
      output mode, in_valid, req, out_ready,
      input  in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
   );
   modport slave (
      input  mode, in_valid, req, out_ready,
      output in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
   );
endinterface

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: registered N-way request encoder with fixed-priority and round-robin arbitration
module prio_enc_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input logic          clk,
   input logic          rst_n,
   prio_enc_rr_if.slave bus
);
   logic [W-1:0]   ptr;
   logic [W-1:0]   fix_idx;
   logic [W-1:0]   rr_idx;
   logic [W-1:0]   win;
   logic [W-1:0]   ptr_nxt;
   logic [N-1:0]   req;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic           in_ready;
   logic           accept;
   logic           any;
   logic           multi;
   logic           out_valid;
   logic [W-1:0]   out_idx;
   logic [N-1:0]   out_onehot;
   logic           out_none;
   logic           out_multi;

   function automatic logic [W-1:0] wrap_add(input logic [W-1:0] p, input int k);
      logic [W:0] s;
      s = {1'b0, p} + (W+1)'(k);
      return (s >= (W+1)'(N)) ? W'(s - (W+1)'(N)) : W'(s);
   endfunction

   assign req      = bus.req;
   assign in_ready = !out_valid || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign any      = |req;
   assign multi    = |(req & (req - N'(1)));
   assign dbl      = {req, req} >> ptr;
   assign rot      = dbl[N-1:0];

   // Fixed priority: scanning upward, the last set bit seen is the highest index
   always_comb begin
      fix_idx = '0;
      for (int i = 0; i < N; i++)
         if (req[i]) fix_idx = W'(i);
   end

   // Round robin: req rotated so ptr sits at bit 0; scanning downward leaves the first set bit at or above ptr
   always_comb begin
      rr_idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (rot[k]) rr_idx = wrap_add(ptr, k);
   end

   assign win     = bus.mode ? rr_idx : fix_idx;
   assign ptr_nxt = (win == W'(N - 1)) ? '0 : win + W'(1);

   // Single output stage: load on accept, clear valid on drain, otherwise hold everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         out_none   <= 1'b0;
         out_multi  <= 1'b0;
         ptr        <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_idx    <= any ? win : '0;
         out_onehot <= any ? N'(1) << win : '0;
         out_none   <= !any;
         out_multi  <= multi;
         if (bus.mode && any) ptr <= ptr_nxt;
      end else if (bus.out_ready) begin
         out_valid  <= 1'b0;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_idx    = out_idx;
   assign bus.out_onehot = out_onehot;
   assign bus.out_none   = out_none;
   assign bus.out_multi  = out_multi;
endmodule

// File: tb/tb_prio_enc_rr.sv
// tb_prio_enc_rr: directed checks of prio_enc_rr for N=8 and N=5
module tb_prio_enc_rr;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   prio_enc_rr_if #(.N(8)) b8 ();
   prio_enc_rr_if #(.N(5)) b5 ();

   prio_enc_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   prio_enc_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive8(input logic v, input logic m, input logic [7:0] r, input logic ordy);
      b8.in_valid  = v;
      b8.mode      = m;
      b8.req       = r;
      b8.out_ready = ordy;
   endtask

   task automatic expect8(input string tag, input logic v, input int idx, input logic [7:0] oh,
                          input logic none, input logic multi);
      check({tag, ".valid"}, b8.out_valid, v);
      check({tag, ".idx"}, b8.out_idx, idx);
      check({tag, ".onehot"}, b8.out_onehot, oh);
      check({tag, ".none"}, b8.out_none, none);
      check({tag, ".multi"}, b8.out_multi, multi);
   endtask

   task automatic expect5(input string tag, input int idx, input logic [4:0] oh);
      check({tag, ".valid"}, b5.out_valid, 1);
      check({tag, ".idx"}, b5.out_idx, idx);
      check({tag, ".range"}, b5.out_idx < 5, 1);
      check({tag, ".onehot"}, b5.out_onehot, oh);
   endtask

   initial begin
      rst_n = 1'b0;
      drive8(0, 0, 8'h00, 1);
      b5.in_valid  = 1'b0;
      b5.mode      = 1'b0;
      b5.req       = '0;
      b5.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      expect8("rst", 0, 0, 8'h00, 0, 0);
      check("rst.in_ready", b8.in_ready, 1);
      check("rst5.valid", b5.out_valid, 0);
      check("rst5.idx", b5.out_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         expect8("idle", 0, 0, 8'h00, 0, 0);
         check("idle.in_ready", b8.in_ready, 1);
      end

      drive8(1, 0, 8'h01, 1);
      @(negedge clk);
      expect8("fp_b0", 1, 0, 8'h01, 0, 0);
      drive8(1, 0, 8'h04, 1);
      @(negedge clk);
      expect8("fp_b2", 1, 2, 8'h04, 0, 0);
      drive8(1, 0, 8'h80, 1);
      @(negedge clk);
      expect8("fp_b7", 1, 7, 8'h80, 0, 0);
      drive8(1, 0, 8'h00, 1);
      @(negedge clk);
      expect8("fp_zero", 1, 0, 8'h00, 1, 0);
      drive8(1, 0, 8'hA6, 1);
      @(negedge clk);
      expect8("fp_multi", 1, 7, 8'h80, 0, 1);
      drive8(0, 0, 8'h00, 1);
      @(negedge clk);
      expect8("drain", 0, 7, 8'h80, 0, 1);

      drive8(1, 1, 8'h92, 1);
      @(negedge clk);
      expect8("rr1", 1, 1, 8'h02, 0, 1);
      @(negedge clk);
      expect8("rr2", 1, 4, 8'h10, 0, 1);
      @(negedge clk);
      expect8("rr3", 1, 7, 8'h80, 0, 1);
      @(negedge clk);
      expect8("rr4", 1, 1, 8'h02, 0, 1);
      drive8(0, 0, 8'h00, 1);
      @(negedge clk);

      drive8(1, 0, 8'h08, 1);
      @(negedge clk);
      expect8("bp_acc", 1, 3, 8'h08, 0, 0);
      drive8(1, 0, 8'h02, 0);
      #1;
      check("bp.in_ready0", b8.in_ready, 0);
      repeat (3) begin
         @(negedge clk);
         expect8("bp_hold", 1, 3, 8'h08, 0, 0);
         check("bp_hold.in_ready", b8.in_ready, 0);
      end
      b8.out_ready = 1'b1;
      #1;
      check("bp.in_ready1", b8.in_ready, 1);
      @(negedge clk);
      expect8("bp_new", 1, 1, 8'h02, 0, 0);
      drive8(0, 0, 8'h00, 1);

      b5.in_valid = 1'b1;
      b5.mode     = 1'b1;
      b5.req      = 5'b10001;
      @(negedge clk);
      expect5("n5_a", 0, 5'b00001);
      @(negedge clk);
      expect5("n5_b", 4, 5'b10000);
      @(negedge clk);
      expect5("n5_c", 0, 5'b00001);
      @(negedge clk);
      expect5("n5_d", 4, 5'b10000);
      b5.in_valid = 1'b0;

      drive8(1, 1, 8'h10, 0);
      @(negedge clk);
      expect8("pre_rst", 1, 4, 8'h10, 0, 0);
      drive8(0, 1, 8'h00, 0);
      rst_n = 1'b0;
      @(negedge clk);
      expect8("mid_rst", 0, 0, 8'h00, 0, 0);
      rst_n = 1'b1;
      drive8(1, 1, 8'h30, 1);
      @(negedge clk);
      expect8("ptr_cleared", 1, 4, 8'h10, 0, 1);
      drive8(1, 1, 8'h06, 1);
      @(negedge clk);
      expect8("ms_rr", 1, 1, 8'h02, 0, 1);
      drive8(1, 0, 8'h06, 1);
      @(negedge clk);
      expect8("ms_fp", 1, 2, 8'h04, 0, 1);
      drive8(1, 1, 8'h06, 1);
      @(negedge clk);
      expect8("ms_rr_kept", 1, 2, 8'h04, 0, 1);
      drive8(0, 0, 8'h00, 1);
      @(negedge clk);
      check("final.valid", b8.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
